apb_slave_decoder: RTL and testbench
====================================

APB_SLAVE_DECODER -- requirements
Module: apb_slave_decoder

Interface
REQ-001 Parameter NO_OF_SLAVES, default 16, number of completer ports (1..16) SHALL be supported.
REQ-002 Parameter ADDRESS_WIDTH, default 32, paddr width.
REQ-003 Parameter DATA_WIDTH, default 32, prdata width (8/16/24/32).
REQ-004 Parameter SLAVE_MEMORY_SIZE, default 12, per-slave window in KB.
REQ-005 Parameter SLAVE_MEMORY_GAP, default 2, unmapped gap after each window in KB.
REQ-006 Parameter TIMEOUT_CYCLES, default 16, max access-phase wait cycles before forced error.
REQ-007 pclk  in  1  single clock, all state on rising edge.
REQ-008 preset  in  1  reset, asynchronous, active-high.
REQ-009 psel, penable  in  1 each  requester setup/access qualifiers.
REQ-010 paddr  in  ADDRESS_WIDTH  requester address.
REQ-011 pselx  out  NO_OF_SLAVES  one-hot completer select, bit i = SLAVE_i.
REQ-012 pready_s, pslverr_s  in  NO_OF_SLAVES each  per-completer responses.
REQ-013 prdata_s  in  NO_OF_SLAVES*DATA_WIDTH  packed per-completer read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 pready, pslverr  out  1 each; prdata  out  DATA_WIDTH  muxed response to requester.
REQ-015 err_count  out  8  saturating count of error completions; last_err_addr  out  ADDRESS_WIDTH  paddr of most recent error.

Function
REQ-016 Window i SHALL be base_i = i*(SIZE+GAP)*1024 through base_i+SIZE*1024-1; any other address (gap or above last window) is unmapped.
REQ-017 FSM states IDLE, ACCESS, ERR_RESP; reset state IDLE.
REQ-018 IDLE: psel=1 & penable=0 SHALL combinationally drive pselx=onehot(decoded index) (all-zero if unmapped), latch index/mapped flag/paddr, go ACCESS (mapped) or ERR_RESP (unmapped).
REQ-019 ACCESS: pselx SHALL hold latched one-hot; pready/pslverr/prdata mirror selected completer; pready_s=1 -> IDLE next edge.
REQ-020 ACCESS: wait counter increments each cycle pready_s=0; when counter reaches TIMEOUT_CYCLES, that cycle pready=1, pslverr=1, prdata=0, go IDLE.
REQ-021 ERR_RESP: pselx all-zero; first cycle with penable=1 SHALL give pready=1, pslverr=1, prdata=0 (zero wait states), go IDLE.
REQ-022 psel=0 while in ACCESS or ERR_RESP SHALL abort to IDLE, no completion, no error counted.
REQ-023 Outside a completing cycle pready=0, pslverr=0, prdata=0.
REQ-024 Every pslverr=1 completion (completer, timeout or unmapped) SHALL increment err_count (saturate at 255) and load last_err_addr with latched paddr.
REQ-025 Back-to-back: setup in cycle after completion SHALL be accepted from IDLE with no bubble.
REQ-026 Wait counter SHALL clear on each entry to ACCESS.

Reset
REQ-027 preset=1 SHALL asynchronously force IDLE, pselx=0, pready=0, pslverr=0, prdata=0, err_count=0, last_err_addr=0, counter=0.
REQ-028 Reset mid-transfer SHALL drop pselx immediately; no completion issued.

Structure
REQ-029 Shared package SHALL hold decoder_state_e enum, TIMEOUT_CYCLES default, and slave base/limit address function, alongside existing NO_OF_SLAVES/ADDRESS_WIDTH/DATA_WIDTH/SLAVE_MEMORY_SIZE/SLAVE_MEMORY_GAP and slave_no_e.
REQ-030 Combinational sub-module apb_addr_decode SHALL map paddr to index and mapped flag.

Verification
REQ-031 paddr=0x3800 (slave 1 base, 14 KB) setup -> pselx=16'h0002; pready_s[1] after 2 waits -> pready=1 on third access cycle, prdata=slave 1 data.
REQ-032 paddr=0x3000 (gap) -> pselx=0; first access cycle pready=1, pslverr=1; err_count=1, last_err_addr=0x3000.
REQ-033 Slave 0 holds pready_s=0 -> pready=1, pslverr=1 after exactly 16 access cycles; err_count increments.
REQ-034 Two back-to-back reads slave 0 then slave 15 (0x34800) -> pselx 0x0001 then 0x8000, no idle cycle between.
REQ-035 preset pulsed mid-ACCESS -> pselx=0 same cycle, err_count=0, next setup decoded normally.
REQ-036 256+ forced errors -> err_count holds 255.

Source files
------------

// File: rtl/apb_slave_decoder_pkg.sv
// Shared types, default geometry and window-address helpers for the APB completer decoder.
package apb_slave_decoder_pkg;

    localparam int NO_OF_SLAVES      = 16;
    localparam int ADDRESS_WIDTH     = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int SLAVE_MEMORY_SIZE = 12;
    localparam int SLAVE_MEMORY_GAP  = 2;
    localparam int TIMEOUT_CYCLES    = 16;

    typedef enum logic [3:0] {
        SLAVE_0,  SLAVE_1,  SLAVE_2,  SLAVE_3,
        SLAVE_4,  SLAVE_5,  SLAVE_6,  SLAVE_7,
        SLAVE_8,  SLAVE_9,  SLAVE_10, SLAVE_11,
        SLAVE_12, SLAVE_13, SLAVE_14, SLAVE_15
    } slave_no_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR_RESP
    } decoder_state_e;

    // Window i starts after i full (window + gap) strides, sizes given in KB.
    function automatic logic [63:0] slave_base(input int idx, input int size_kb, input int gap_kb);
        return 64'(idx) * 64'(size_kb + gap_kb) * 64'd1024;
    endfunction

    function automatic logic [63:0] slave_limit(input int idx, input int size_kb, input int gap_kb);
        return slave_base(idx, size_kb, gap_kb) + 64'(size_kb) * 64'd1024 - 64'd1;
    endfunction

endpackage

// File: rtl/apb_slave_decoder_if.sv
// APB bus bundle: requester qualifiers/address, per-completer responses, and the decoder's outputs.
interface apb_slave_decoder_if #(
    parameter int NO_OF_SLAVES  = apb_slave_decoder_pkg::NO_OF_SLAVES,
    parameter int ADDRESS_WIDTH = apb_slave_decoder_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = apb_slave_decoder_pkg::DATA_WIDTH
);

    logic                                psel;
    logic                                penable;
    logic [ADDRESS_WIDTH-1:0]            paddr;
    logic [NO_OF_SLAVES-1:0]             pselx;
    logic [NO_OF_SLAVES-1:0]             pready_s;
    logic [NO_OF_SLAVES-1:0]             pslverr_s;
    logic [NO_OF_SLAVES*DATA_WIDTH-1:0]  prdata_s;
    logic                                pready;
    logic                                pslverr;
    logic [DATA_WIDTH-1:0]               prdata;

    // master: everything around the decoder (requester plus completers)
    modport master (
        output psel, penable, paddr, pready_s, pslverr_s, prdata_s,
        input  pselx, pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, paddr, pready_s, pslverr_s, prdata_s,
        output pselx, pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_slave_decoder_addr_decode.sv
// Combinational address map: finds which completer window (if any) contains paddr.
module apb_addr_decode #(
    parameter int NO_OF_SLAVES      = apb_slave_decoder_pkg::NO_OF_SLAVES,
    parameter int ADDRESS_WIDTH     = apb_slave_decoder_pkg::ADDRESS_WIDTH,
    parameter int SLAVE_MEMORY_SIZE = apb_slave_decoder_pkg::SLAVE_MEMORY_SIZE,
    parameter int SLAVE_MEMORY_GAP  = apb_slave_decoder_pkg::SLAVE_MEMORY_GAP
) (
    input  logic [ADDRESS_WIDTH-1:0]          paddr,
    output apb_slave_decoder_pkg::slave_no_e  idx,
    output logic                              mapped
);
    import apb_slave_decoder_pkg::*;

    logic [63:0] addr_ext;

    always_comb begin
        addr_ext = 64'(paddr);
        idx      = SLAVE_0;
        mapped   = 1'b0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (addr_ext >= slave_base(i, SLAVE_MEMORY_SIZE, SLAVE_MEMORY_GAP) &&
                addr_ext <= slave_limit(i, SLAVE_MEMORY_SIZE, SLAVE_MEMORY_GAP)) begin
                idx    = slave_no_e'(4'(i));
                mapped = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_slave_decoder.sv
// APB completer decoder: selects one completer per transfer, muxes its response back,
// answers unmapped/hung accesses with an error and keeps error statistics.
module apb_slave_decoder #(
    parameter int NO_OF_SLAVES      = apb_slave_decoder_pkg::NO_OF_SLAVES,
    parameter int ADDRESS_WIDTH     = apb_slave_decoder_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = apb_slave_decoder_pkg::DATA_WIDTH,
    parameter int SLAVE_MEMORY_SIZE = apb_slave_decoder_pkg::SLAVE_MEMORY_SIZE,
    parameter int SLAVE_MEMORY_GAP  = apb_slave_decoder_pkg::SLAVE_MEMORY_GAP,
    parameter int TIMEOUT_CYCLES    = apb_slave_decoder_pkg::TIMEOUT_CYCLES
) (
    input  logic                      pclk,
    input  logic                      preset,
    apb_slave_decoder_if.slave        bus,
    output logic [7:0]                err_count,
    output logic [ADDRESS_WIDTH-1:0]  last_err_addr
);
    import apb_slave_decoder_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    decoder_state_e           state_q, state_d;
    slave_no_e                idx_q, idx_d, dec_idx;
    logic                     mapped_q, mapped_d, dec_mapped;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [7:0]               err_cnt_q, err_cnt_d;
    logic [ADDRESS_WIDTH-1:0] last_err_q, last_err_d;

    logic                     sel_ready, sel_err, timeout;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [NO_OF_SLAVES-1:0]  pselx_c;
    logic                     pready_c, pslverr_c;
    logic [DATA_WIDTH-1:0]    prdata_c;

    apb_addr_decode #(
        .NO_OF_SLAVES      (NO_OF_SLAVES),
        .ADDRESS_WIDTH     (ADDRESS_WIDTH),
        .SLAVE_MEMORY_SIZE (SLAVE_MEMORY_SIZE),
        .SLAVE_MEMORY_GAP  (SLAVE_MEMORY_GAP)
    ) u_decode (
        .paddr  (bus.paddr),
        .idx    (dec_idx),
        .mapped (dec_mapped)
    );

    function automatic logic [NO_OF_SLAVES-1:0] onehot(input slave_no_e i);
        return NO_OF_SLAVES'(1) << i;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mapped_d   = mapped_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        pselx_c    = '0;
        pready_c   = 1'b0;
        pslverr_c  = 1'b0;
        prdata_c   = '0;

        sel_ready = bus.pready_s[idx_q];
        sel_err   = bus.pslverr_s[idx_q];
        sel_data  = bus.prdata_s[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    pselx_c  = dec_mapped ? onehot(dec_idx) : '0;
                    idx_d    = dec_idx;
                    mapped_d = dec_mapped;
                    addr_d   = bus.paddr;
                    cnt_d    = '0;
                    state_d  = dec_mapped ? ACCESS : ERR_RESP;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else begin
                    pselx_c = mapped_q ? onehot(idx_q) : '0;
                    // A hung completer is cut off even if it answers on the same cycle.
                    if (timeout) begin
                        pready_c  = 1'b1;
                        pslverr_c = 1'b1;
                        state_d   = IDLE;
                    end else if (sel_ready) begin
                        pready_c  = 1'b1;
                        pslverr_c = sel_err;
                        prdata_c  = sel_data;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR_RESP: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    pready_c  = 1'b1;
                    pslverr_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pready_c && pslverr_c) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            last_err_d = addr_q;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            idx_q      <= SLAVE_0;
            mapped_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mapped_q   <= mapped_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    // Reset must silence the bus immediately, including the combinational setup select.
    assign bus.pselx   = preset ? '0   : pselx_c;
    assign bus.pready  = preset ? 1'b0 : pready_c;
    assign bus.pslverr = preset ? 1'b0 : pslverr_c;
    assign bus.prdata  = preset ? '0   : prdata_c;

    assign err_count     = err_cnt_q;
    assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_apb_slave_decoder.sv
// Scoreboard bench for apb_slave_decoder: an APB requester task plus a per-transfer completer model.
module tb_apb_slave_decoder;

    localparam int N       = 16;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SIZE_KB = 12;
    localparam int GAP_KB  = 2;
    localparam int TMO     = 16;
    localparam longint unsigned STRIDE = longint'((SIZE_KB + GAP_KB) * 1024);

    logic pclk = 1'b0;
    logic preset;
    logic [7:0]    err_count;
    logic [AW-1:0] last_err_addr;

    always #5 pclk = ~pclk;

    apb_slave_decoder_if #(.NO_OF_SLAVES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_slave_decoder #(
        .NO_OF_SLAVES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_MEMORY_SIZE(SIZE_KB), .SLAVE_MEMORY_GAP(GAP_KB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .bus           (bus),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    typedef struct {
        int            lat;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int unsigned   m_err_cnt = 0;
    logic [AW-1:0] m_last_err = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sdata(input int i);
        return {16'hC0DE, 8'(i), 8'(255 - i)};
    endfunction

    function automatic void model_decode(input logic [AW-1:0] a, output bit mapped, output int idx);
        longint unsigned av = longint'({32'b0, a});
        longint unsigned q  = av / STRIDE;
        mapped = (q < longint'(N)) && ((av % STRIDE) < longint'(SIZE_KB * 1024));
        idx    = mapped ? int'(q) : 0;
    endfunction

    // waits < 0: the addressed completer never raises pready_s
    task automatic xfer(input logic [AW-1:0] a, input int waits, input bit serr);
        bit            mapped;
        bit            done;
        int            idx;
        exp_t          e;
        logic [N-1:0]  sel;
        model_decode(a, mapped, idx);
        sel = mapped ? (N'(1) << idx) : '0;
        if (!mapped) begin
            e.lat = 1; e.err = 1'b1; e.data = '0;
        end else if (waits < 0) begin
            e.lat = TMO + 1; e.err = 1'b1; e.data = '0;
        end else begin
            e.lat = waits + 1; e.err = serr; e.data = sdata(idx);
        end
        sb.push_back(e);

        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a;
        bus.pready_s = '0; bus.pslverr_s = '0;
        @(negedge pclk);
        chk("setup_pselx", 64'(bus.pselx), 64'(sel));
        chk("setup_pready", 64'(bus.pready), 64'd0);
        chk("err_count", 64'(err_count), 64'(m_err_cnt));
        chk("last_err_addr", 64'(last_err_addr), 64'(m_last_err));

        @(posedge pclk); #1;
        bus.penable = 1'b1;
        done = 1'b0;
        for (int cyc = 1; cyc <= TMO + 8 && !done; cyc++) begin
            bus.pready_s  = (mapped && waits >= 0 && cyc > waits) ? sel : '0;
            bus.pslverr_s = serr ? sel : '0;
            @(negedge pclk);
            chk("access_pselx", 64'(bus.pselx), 64'(sel));
            if (bus.pready) begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(e.lat));
                chk("pslverr", 64'(bus.pslverr), 64'(e.err));
                chk("prdata", 64'(bus.prdata), 64'(e.data));
                if (e.err) begin
                    if (m_err_cnt < 255) m_err_cnt++;
                    m_last_err = a;
                end
                done = 1'b1;
            end else begin
                chk("wait_prdata", 64'(bus.prdata), 64'd0);
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL no_completion: got no pready, want pready within %0d cycles (addr 0x%0h)", TMO + 8, a);
            void'(sb.pop_front());
        end
    endtask

    task automatic idle(input int n);
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        bus.pready_s = '0; bus.pslverr_s = '0;
        repeat (n) @(posedge pclk);
        @(negedge pclk);
        chk("idle_pselx", 64'(bus.pselx), 64'd0);
        chk("idle_pready", 64'(bus.pready), 64'd0);
    endtask

    initial begin
        preset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0;
        bus.pready_s = '0; bus.pslverr_s = '0;
        for (int i = 0; i < N; i++) bus.prdata_s[i*DW +: DW] = sdata(i);

        // Reset state, with a setup presented so the forced-off select is exercised
        repeat (2) @(posedge pclk);
        #1 bus.psel = 1'b1;
        @(negedge pclk);
        chk("rst_pselx", 64'(bus.pselx), 64'd0);
        chk("rst_pready", 64'(bus.pready), 64'd0);
        chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
        chk("rst_prdata", 64'(bus.prdata), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_last_err", 64'(last_err_addr), 64'd0);
        @(posedge pclk); #1;
        preset = 1'b0; bus.psel = 1'b0;

        xfer(32'h0000_3800, 2, 1'b0);      // slave 1, two waits
        xfer(32'h0000_3000, 0, 1'b0);      // gap after slave 0
        xfer(32'h0000_0000, 0, 1'b0);      // back-to-back slave 0 ...
        xfer(32'h0003_4800, 0, 1'b0);      // ... then slave 15
        xfer(32'h0000_0010, -1, 1'b0);     // slave 0 hangs -> timeout
        xfer(32'h0000_2FFF, 1, 1'b1);      // last byte of slave 0, completer error
        xfer(32'h0003_77FF, 0, 1'b0);      // last byte of slave 15
        xfer(32'h0003_7800, 0, 1'b0);      // above the last window
        xfer(32'h0000_37FF, 0, 1'b0);      // last byte of first gap
        xfer(32'hFFFF_FFFF, 0, 1'b0);
        for (int i = 0; i < N; i++)
            xfer(AW'(longint'(i) * STRIDE + longint'(i * 4)), i % 3, 1'b0);
        idle(2);
        chk("err_count_mid", 64'(err_count), 64'(m_err_cnt));
        chk("last_err_mid", 64'(last_err_addr), 64'(m_last_err));

        // Abort: requester drops psel while slave 3 is still waiting
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0000_A800;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            chk("abort_wait_pready", 64'(bus.pready), 64'd0);
            @(posedge pclk); #1;
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        chk("abort_pready", 64'(bus.pready), 64'd0);
        chk("abort_pselx", 64'(bus.pselx), 64'd0);
        idle(1);
        chk("abort_err_count", 64'(err_count), 64'(m_err_cnt));

        // Asynchronous reset in the middle of an access to slave 2
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0000_7000;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        chk("pre_rst_pselx", 64'(bus.pselx), 64'h0004);
        @(posedge pclk); #2;
        preset = 1'b1;
        #1;
        chk("midrst_pselx", 64'(bus.pselx), 64'd0);
        chk("midrst_pready", 64'(bus.pready), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_last_err", 64'(last_err_addr), 64'd0);
        m_err_cnt  = 0;
        m_last_err = '0;
        @(posedge pclk); #1;
        preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        idle(1);
        xfer(32'h0000_7000, 0, 1'b0);
        xfer(32'h0000_7004, 1, 1'b1);

        // Saturation of the error counter
        for (int k = 0; k < 260; k++)
            xfer(AW'(32'h0000_3000 + (k % 32'h800)), 0, 1'b0);
        idle(1);
        chk("sat_err_count", 64'(err_count), 64'd255);
        chk("sat_model", 64'(err_count), 64'(m_err_cnt));
        chk("sat_last_err", 64'(last_err_addr), 64'(m_last_err));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
